// File: rtl/battle_turn_controller_if.sv
// Handshake bundle between the battle turn controller and its neighbours.
// master drives the player/boss status inputs; slave is the controller itself.
interface battle_turn_controller_if;
    logic       start;
    logic       attack_btn;
    logic       you_lose;
    logic       boss_defeated;
    logic [2:0] phase;
    logic       health_enable;
    logic       bullet_enable;
    logic       health_reset;
    logic       hit_pulse;
    logic [3:0] seconds_left;
    logic [7:0] turn_count;
    logic       victory;
    logic       game_over;

    modport master (
        output start, attack_btn, you_lose, boss_defeated,
        input  phase, health_enable, bullet_enable, health_reset, hit_pulse,
        input  seconds_left, turn_count, victory, game_over
    );

    modport slave (
        input  start, attack_btn, you_lose, boss_defeated,
        output phase, health_enable, bullet_enable, health_reset, hit_pulse,
        output seconds_left, turn_count, victory, game_over
    );
endinterface

// File: rtl/battle_turn_controller.sv
// Boss battle sequencer: alternates timed player and boss turns, watches the
// win/lose levels and latches the result until the next start pulse.
module battle_turn_controller #(
    parameter int unsigned TICKS_PER_SEC   = 50_000_000,
    parameter int unsigned PLAYER_TURN_SEC = 3,
    parameter int unsigned BOSS_TURN_SEC   = 5
) (
    input logic                     CLOCK_50,
    input logic                     reset,
    battle_turn_controller_if.slave bus
);

    localparam int unsigned       TICK_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]        PLAYER_LEN = 4'(PLAYER_TURN_SEC);
    localparam logic [3:0]        BOSS_LEN   = 4'(BOSS_TURN_SEC);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPlayer  = 3'd1,
        StBoss    = 3'd2,
        StVictory = 3'd3,
        StDefeat  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [3:0]        secs_q, secs_d;
    logic [7:0]        turn_q, turn_d;
    logic              attack_q;
    logic              health_reset_q, health_reset_d;
    logic              hit_q, hit_d;
    logic              health_en_q, bullet_en_q, victory_q, game_over_q;

    logic in_turn, tick, expire, attack_rise, entering;

    assign in_turn     = (state_q == StPlayer) || (state_q == StBoss);
    assign tick        = in_turn && (tick_q == TICK_LAST);
    assign expire      = tick && (secs_q == 4'd1);
    assign attack_rise = bus.attack_btn && !attack_q;
    assign entering    = (state_d != state_q);

    // State and datapath registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            tick_q         <= '0;
            secs_q         <= 4'd0;
            turn_q         <= 8'd0;
            attack_q       <= 1'b0;
            health_reset_q <= 1'b0;
            hit_q          <= 1'b0;
            health_en_q    <= 1'b0;
            bullet_en_q    <= 1'b0;
            victory_q      <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_q         <= tick_d;
            secs_q         <= secs_d;
            turn_q         <= turn_d;
            attack_q       <= bus.attack_btn;
            health_reset_q <= health_reset_d;
            hit_q          <= hit_d;
            health_en_q    <= (state_d == StPlayer);
            bullet_en_q    <= (state_d == StBoss);
            victory_q      <= (state_d == StVictory);
            game_over_q    <= (state_d == StVictory) || (state_d == StDefeat);
        end
    end

    // Next-state: losing outranks winning, which outranks the attack and the timer
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.start) state_d = StPlayer;
            end
            StPlayer: begin
                if (bus.you_lose)                state_d = StDefeat;
                else if (bus.boss_defeated)      state_d = StVictory;
                else if (attack_rise || expire)  state_d = StBoss;
            end
            StBoss: begin
                if (bus.you_lose)                state_d = StDefeat;
                else if (bus.boss_defeated)      state_d = StVictory;
                else if (expire)                 state_d = StPlayer;
            end
            StVictory, StDefeat: begin
                if (bus.start) state_d = StPlayer;
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered-output next values
    always_comb begin
        health_reset_d = (state_d == StPlayer) &&
                         ((state_q == StIdle) || (state_q == StVictory) || (state_q == StDefeat));
        hit_d          = (state_q == StPlayer) && (state_d == StBoss) && attack_rise;

        // Counter restarts on every entry so each turn is exactly LEN seconds long
        if (entering || !in_turn || tick) tick_d = '0;
        else                              tick_d = tick_q + TICK_W'(1);

        if (entering) begin
            case (state_d)
                StPlayer: secs_d = PLAYER_LEN;
                StBoss:   secs_d = BOSS_LEN;
                default:  secs_d = 4'd0;
            endcase
        end else if (tick) begin
            secs_d = secs_q - 4'd1;
        end else begin
            secs_d = secs_q;
        end

        if (health_reset_d) begin
            turn_d = 8'd0;
        end else if ((state_q == StBoss) && (state_d == StPlayer) && (turn_q != 8'hFF)) begin
            turn_d = turn_q + 8'd1;
        end else begin
            turn_d = turn_q;
        end
    end

    assign bus.phase         = state_q;
    assign bus.health_enable = health_en_q;
    assign bus.bullet_enable = bullet_en_q;
    assign bus.health_reset  = health_reset_q;
    assign bus.hit_pulse     = hit_q;
    assign bus.seconds_left  = secs_q;
    assign bus.turn_count    = turn_q;
    assign bus.victory       = victory_q;
    assign bus.game_over     = game_over_q;

endmodule
